mips_pipe_ctrl: RTL and testbench

Parametrised pipeline sequencing unit for the MIPS core. It generates per-stage enable, valid and flush signals for an N-stage in-order pipeline, with stage 0 = IF, 1 = ID, 2 = EXE, STAGES-2 = MEM and STAGES-1 = WB. It tracks in-flight load destinations in an internal shift scoreboard for load-use interlock, and handles branch flush and memory-ready back-pressure. It saturates hazard performance counters. It sits between the controller's decode and the datapath's stage registers.

---
 rtl/mips_pipe_ctrl_pkg.sv | 31 +++
 rtl/mips_pipe_ctrl_sat_counter.sv | 31 +++
 rtl/mips_pipe_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_mips_pipe_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_ctrl_pkg.sv
// mips_pipe_ctrl_pkg
// Shared definitions for the pipeline sequencing unit.
//   - Stage index constants: IF = 0, ID = 1, EXE = 2, MEM = STAGES-2,
//     WB = STAGES-1 (MEM/WB depend on depth, so they are helper functions).
//   - Scoreboard entry layout: {vld, is_load, wen, addr[REG_AW-1:0]}.
//     The address width is a module parameter, so the packed struct itself
//     is declared in the top; SB_CTRL_W gives the width of the control
//     fields that sit above the address.
package mips_pipe_ctrl_pkg;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EXE = 2;

  // Control bits of one scoreboard entry: vld, is_load, wen.
  localparam int SB_CTRL_W = 3;

  function automatic int mem_idx(input int stages);
    return stages - 2;
  endfunction

  function automatic int wb_idx(input int stages);
    return stages - 1;
  endfunction

  // Tracked entries cover EXE .. MEM-1.
  function automatic int sb_depth(input int stages);
    return mem_idx(stages) - STG_EXE;
  endfunction

endpackage

// File: rtl/mips_pipe_ctrl_sat_counter.sv
// mips_sat_counter
// Saturating up-counter used for the hazard performance counters.
// Ports:
//   clk  - core clock
//   rst  - asynchronous active-low reset, clears the count
//   inc  - count one event this cycle
//   cnt  - current count, sticks at all ones
module mips_sat_counter
  import mips_pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/mips_pipe_ctrl.sv
// mips_pipe_ctrl
// Pipeline sequencing unit: per-stage enable / valid / flush for an
// in-order pipeline of STAGES stages (IF, ID, EXE, extra EXE stages, MEM, WB).
// A shift scoreboard of in-flight instructions between EXE and MEM drives
// the load-use interlock; dmem back-pressure freezes the whole pipe; a taken
// branch in ID squashes the wrong-path fetch; a missing fetch inserts an ID
// bubble.
// Optional build macro: MIPS_PIPE_DEBUG_STEP_EN adds debug_en/debug_step
// single-step control (pipe frozen while debug_en, except one cycle per
// synchronised rising edge of debug_step).
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   id_*                     - decode information for the instruction in ID
//   imem_ready, dmem_ready   - memory handshakes
//   stage_en/valid/flush     - per-stage control, bit i = stage i
//   load_stall_cnt           - cycles lost to load-use interlock
//   mem_stall_cnt            - cycles lost to dmem_ready low
module mips_pipe_ctrl
  import mips_pipe_ctrl_pkg::*;
#(
  parameter int STAGES = 5,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
`ifdef MIPS_PIPE_DEBUG_STEP_EN
  input  logic              debug_en,
  input  logic              debug_step,
`endif
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_is_load,
  input  logic              id_wb_wen,
  input  logic [REG_AW-1:0] id_regw_addr,
  input  logic              id_branch_taken,
  input  logic              imem_ready,
  input  logic              dmem_ready,
  output logic [STAGES-1:0] stage_en,
  output logic [STAGES-1:0] stage_valid,
  output logic [STAGES-1:0] stage_flush,
  output logic [CNT_W-1:0]  load_stall_cnt,
  output logic [CNT_W-1:0]  mem_stall_cnt
);

  localparam int STG_MEM = mem_idx(STAGES);
  localparam int SB_N    = sb_depth(STAGES);

  typedef struct packed {
    logic              vld;
    logic              is_load;
    logic              wen;
    logic [REG_AW-1:0] addr;
  } sb_entry_t;

  logic [STAGES-1:0] valid;
  sb_entry_t         sb [SB_N];
  logic [STAGES-1:0] en;
  logic [STAGES-1:0] flush;
  logic              mem_wait;
  logic              load_hit;
  logic              fetch_wait;
  logic              branch;
  logic              frozen;

  function automatic logic entry_hit(input sb_entry_t e,
                                     input logic [REG_AW-1:0] rs,
                                     input logic [REG_AW-1:0] rt,
                                     input logic rs_use,
                                     input logic rt_use);
    return e.vld & e.is_load & e.wen & (e.addr != '0) &
           ((rs_use & (e.addr == rs)) | (rt_use & (e.addr == rt)));
  endfunction

`ifdef MIPS_PIPE_DEBUG_STEP_EN
  // Two synchroniser flops plus one history flop for edge detection; the
  // detected edge is registered so the pipe runs on exactly one cycle.
  logic [2:0] step_sync;
  logic       step_go;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_sync <= '0;
      step_go   <= 1'b0;
    end else begin
      step_sync <= {step_sync[1:0], debug_step};
      step_go   <= step_sync[1] & ~step_sync[2];
    end
  end

  assign frozen = debug_en & ~step_go;
`else
  assign frozen = 1'b0;
`endif

  assign mem_wait   = valid[STG_MEM] & ~dmem_ready;
  assign fetch_wait = ~imem_ready;
  assign branch     = id_branch_taken & valid[STG_ID];

  always_comb begin
    load_hit = 1'b0;
    for (int k = 0; k < SB_N; k++) begin
      load_hit = load_hit |
                 entry_hit(sb[k], id_rs_addr, id_rt_addr, id_rs_used, id_rt_used);
    end
    load_hit = load_hit & valid[STG_ID];
  end

  // Hazard priority: reset, freeze/mem_wait, load-use, branch, fetch wait.
  always_comb begin
    en    = '1;
    flush = '0;
    if (!rst) begin
      en    = '0;
      flush = '1;
    end else if (frozen || mem_wait) begin
      en = '0;
    end else if (load_hit) begin
      en[STG_IF]     = 1'b0;
      en[STG_ID]     = 1'b0;
      flush[STG_EXE] = 1'b1;
    end else begin
      if (branch) begin
        flush[STG_ID] = 1'b1;
      end
      // Still holds IF when combined with a branch.
      if (fetch_wait) begin
        en[STG_IF]    = 1'b0;
        flush[STG_ID] = 1'b1;
      end
    end
  end

  // Valid and scoreboard shift; WB valid simply falls off the end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      for (int k = 0; k < SB_N; k++) begin
        sb[k] <= '0;
      end
    end else begin
      valid[STG_IF] <= 1'b1;
      for (int i = 1; i < STAGES; i++) begin
        if (en[i]) begin
          valid[i] <= flush[i] ? 1'b0 : valid[i-1];
        end
      end
      if (en[STG_EXE]) begin
        if (flush[STG_EXE]) begin
          sb[0] <= '0;
        end else begin
          sb[0].vld     <= valid[STG_ID];
          sb[0].is_load <= id_is_load;
          sb[0].wen     <= id_wb_wen;
          sb[0].addr    <= id_regw_addr;
        end
      end
      for (int k = 1; k < SB_N; k++) begin
        if (en[STG_EXE+k]) begin
          sb[k] <= sb[k-1];
        end
      end
    end
  end

  assign stage_en    = en;
  assign stage_flush = flush;
  assign stage_valid = valid;

  mips_sat_counter #(.CNT_W(CNT_W)) u_load_cnt (
    .clk (clk),
    .rst (rst),
    .inc (~frozen & ~mem_wait & load_hit),
    .cnt (load_stall_cnt)
  );

  mips_sat_counter #(.CNT_W(CNT_W)) u_mem_cnt (
    .clk (clk),
    .rst (rst),
    .inc (~frozen & mem_wait),
    .cnt (mem_stall_cnt)
  );

endmodule

// File: tb/tb_mips_pipe_ctrl.sv
// tb_mips_pipe_ctrl
// Directed bench for mips_pipe_ctrl. Two instances share one stimulus set:
// d5 (STAGES=5, CNT_W=3, so saturation is reachable quickly) and
// d7 (STAGES=7, CNT_W=16) for the deeper load-use interlock.
module tb_mips_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs_addr, id_rt_addr, id_regw_addr;
  logic       id_rs_used, id_rt_used, id_is_load, id_wb_wen, id_branch_taken;
  logic       imem_ready, dmem_ready;

  logic [4:0]  en5, val5, fl5;
  logic [2:0]  lcnt5, mcnt5;
  logic [6:0]  en7, val7, fl7;
  logic [15:0] lcnt7, mcnt7;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mips_pipe_ctrl #(.STAGES(5), .REG_AW(5), .CNT_W(3)) d5 (
    .clk(clk), .rst(rst),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_is_load(id_is_load), .id_wb_wen(id_wb_wen),
    .id_regw_addr(id_regw_addr), .id_branch_taken(id_branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .stage_en(en5), .stage_valid(val5), .stage_flush(fl5),
    .load_stall_cnt(lcnt5), .mem_stall_cnt(mcnt5)
  );

  mips_pipe_ctrl #(.STAGES(7), .REG_AW(5), .CNT_W(16)) d7 (
    .clk(clk), .rst(rst),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_is_load(id_is_load), .id_wb_wen(id_wb_wen),
    .id_regw_addr(id_regw_addr), .id_branch_taken(id_branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .stage_en(en7), .stage_valid(val7), .stage_flush(fl7),
    .load_stall_cnt(lcnt7), .mem_stall_cnt(mcnt7)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle;
    id_rs_addr = '0; id_rt_addr = '0; id_regw_addr = '0;
    id_rs_used = 1'b0; id_rt_used = 1'b0;
    id_is_load = 1'b0; id_wb_wen = 1'b0; id_branch_taken = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b1;
  endtask

  task automatic drive_load(input logic [4:0] dst);
    set_idle;
    id_is_load = 1'b1; id_wb_wen = 1'b1; id_regw_addr = dst;
  endtask

  task automatic drive_use_rs(input logic [4:0] src);
    set_idle;
    id_rs_addr = src; id_rs_used = 1'b1; id_wb_wen = 1'b1; id_regw_addr = 5'd6;
  endtask

  // Reset, release, then run until both pipes are full.
  task automatic reset_fill;
    set_idle;
    rst = 1'b0;
    tick;
    rst = 1'b1;
    repeat (7) tick;
  endtask

  task automatic test_reset;
    logic [4:0] exp;
    set_idle;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    total++; if (val5 !== 5'b00000) begin bad++; $display("FAIL reset_valid got=%b want=%b", val5, 5'b00000); end
    total++; if (en5 !== 5'b00000) begin bad++; $display("FAIL reset_en got=%b want=%b", en5, 5'b00000); end
    total++; if (fl5 !== 5'b11111) begin bad++; $display("FAIL reset_flush got=%b want=%b", fl5, 5'b11111); end
    total++; if (fl7 !== 7'h7F) begin bad++; $display("FAIL reset_flush7 got=%b want=%b", fl7, 7'h7F); end
    total++; if (lcnt5 !== 3'd0 || mcnt5 !== 3'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", lcnt5, mcnt5); end
    tick;
    rst = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick;
      exp = 5'((1 << i) - 1);
      total++; if (val5 !== exp) begin bad++; $display("FAIL fill_valid step=%0d got=%b want=%b", i, val5, exp); end
    end
    total++; if (en5 !== 5'b11111 || fl5 !== 5'b00000) begin bad++; $display("FAIL fill_ctrl got=%b/%b want=11111/00000", en5, fl5); end
    total++; if (lcnt5 !== 3'd0 || mcnt5 !== 3'd0) begin bad++; $display("FAIL fill_cnt got=%0d/%0d want=0/0", lcnt5, mcnt5); end
  endtask

  task automatic test_load_use;
    reset_fill;
    drive_load(5'd5);
    #1;
    total++; if (en5 !== 5'b11111) begin bad++; $display("FAIL lu_pre_en got=%b want=11111", en5); end
    tick;
    drive_use_rs(5'd5);
    #1;
    total++; if (en5 !== 5'b11100) begin bad++; $display("FAIL lu_stall_en got=%b want=11100", en5); end
    total++; if (fl5 !== 5'b00100) begin bad++; $display("FAIL lu_stall_flush got=%b want=00100", fl5); end
    tick;
    total++; if (lcnt5 !== 3'd1) begin bad++; $display("FAIL lu_cnt got=%0d want=1", lcnt5); end
    total++; if (val5 !== 5'b11011) begin bad++; $display("FAIL lu_bubble_valid got=%b want=11011", val5); end
    total++; if (en5 !== 5'b11111 || fl5 !== 5'b00000) begin bad++; $display("FAIL lu_release got=%b/%b want=11111/00000", en5, fl5); end
    tick;
    total++; if (val5 !== 5'b10111) begin bad++; $display("FAIL lu_after_valid got=%b want=10111", val5); end
    // Load followed by a branch that also consumes the load: stall wins.
    drive_load(5'd9);
    tick;
    drive_use_rs(5'd9);
    id_branch_taken = 1'b1;
    #1;
    total++; if (en5 !== 5'b11100 || fl5 !== 5'b00100) begin bad++; $display("FAIL lu_branch got=%b/%b want=11100/00100", en5, fl5); end
    tick;
    total++; if (fl5 !== 5'b00010) begin bad++; $display("FAIL lu_branch_retry got=%b want=00010", fl5); end
    set_idle;
  endtask

  task automatic test_load_use_deep;
    int stalls;
    reset_fill;
    drive_load(5'd5);
    tick;
    drive_use_rs(5'd5);
    stalls = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (c == 0) begin
        total++; if (en7 !== 7'b1111100 || fl7 !== 7'b0000100) begin bad++; $display("FAIL deep_first got=%b/%b want=1111100/0000100", en7, fl7); end
      end
      if (en7[1] === 1'b0) stalls++;
      tick;
    end
    total++; if (stalls != 3) begin bad++; $display("FAIL deep_stalls got=%0d want=3", stalls); end
    total++; if (lcnt7 !== 16'd3) begin bad++; $display("FAIL deep_cnt got=%0d want=3", lcnt7); end
    set_idle;
  endtask

  task automatic test_zero_reg;
    reset_fill;
    drive_load(5'd0);
    tick;
    drive_use_rs(5'd0);
    #1;
    total++; if (en5 !== 5'b11111) begin bad++; $display("FAIL zero_en got=%b want=11111", en5); end
    tick;
    total++; if (lcnt5 !== 3'd0) begin bad++; $display("FAIL zero_cnt got=%0d want=0", lcnt5); end
    set_idle;
  endtask

  task automatic test_branch;
    reset_fill;
    id_branch_taken = 1'b1;
    #1;
    total++; if (en5 !== 5'b11111 || fl5 !== 5'b00010) begin bad++; $display("FAIL br_ctrl got=%b/%b want=11111/00010", en5, fl5); end
    tick;
    total++; if (val5 !== 5'b11101) begin bad++; $display("FAIL br_valid got=%b want=11101", val5); end
    id_branch_taken = 1'b0;
    tick;
    total++; if (val5 !== 5'b11011) begin bad++; $display("FAIL br_after got=%b want=11011", val5); end
    id_branch_taken = 1'b1;
    imem_ready = 1'b0;
    #1;
    total++; if (en5 !== 5'b11110 || fl5 !== 5'b00010) begin bad++; $display("FAIL br_fetch got=%b/%b want=11110/00010", en5, fl5); end
    tick;
    total++; if (val5 !== 5'b10101) begin bad++; $display("FAIL br_fetch_valid got=%b want=10101", val5); end
    set_idle;
  endtask

  task automatic test_mem_stall;
    reset_fill;
    drive_load(5'd5);
    tick;
    drive_use_rs(5'd5);
    dmem_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++; if (en5 !== 5'b00000 || fl5 !== 5'b00000) begin bad++; $display("FAIL mem_freeze c=%0d got=%b/%b want=00000/00000", c, en5, fl5); end
      tick;
    end
    dmem_ready = 1'b1;
    total++; if (mcnt5 !== 3'd4) begin bad++; $display("FAIL mem_cnt got=%0d want=4", mcnt5); end
    total++; if (lcnt5 !== 3'd0) begin bad++; $display("FAIL mem_lu_cnt got=%0d want=0", lcnt5); end
    #1;
    total++; if (en5 !== 5'b11100) begin bad++; $display("FAIL mem_then_lu got=%b want=11100", en5); end
    tick;
    total++; if (lcnt5 !== 3'd1) begin bad++; $display("FAIL mem_lu_after got=%0d want=1", lcnt5); end
    set_idle;
  endtask

  task automatic test_saturate_async_reset;
    reset_fill;
    dmem_ready = 1'b0;
    repeat (8) tick;
    total++; if (mcnt5 !== 3'd7) begin bad++; $display("FAIL sat_reach got=%0d want=7", mcnt5); end
    repeat (3) tick;
    total++; if (mcnt5 !== 3'd7) begin bad++; $display("FAIL sat_hold got=%0d want=7", mcnt5); end
    total++; if (mcnt7 !== 16'd11) begin bad++; $display("FAIL sat_wide got=%0d want=11", mcnt7); end
    #2 rst = 1'b0;
    #1;
    total++; if (val5 !== 5'b00000 || en5 !== 5'b00000 || fl5 !== 5'b11111) begin bad++; $display("FAIL async_ctrl got=%b/%b/%b want=00000/00000/11111", val5, en5, fl5); end
    total++; if (mcnt5 !== 3'd0 || lcnt5 !== 3'd0) begin bad++; $display("FAIL async_cnt got=%0d/%0d want=0/0", mcnt5, lcnt5); end
    set_idle;
    tick;
    rst = 1'b1;
  endtask

  initial begin
    test_reset;
    test_load_use;
    test_load_use_deep;
    test_zero_reg;
    test_branch;
    test_mem_stall;
    test_saturate_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
